// File: rtl/core_pkg.sv
// core_pkg: shared types for the memory port arbiter
// and its big-endian byte-lane helper.
package core_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AR   = 3'd1,
      R    = 3'd2,
      W    = 3'd3,
      B    = 3'd4,
      DONE = 3'd5
   } arb_state_t;

   localparam logic [2:0] MISALIGN_VEC = 3'd0;

   typedef struct packed {
      logic        is_instr;
      mem_size_t   size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

   function automatic logic misaligned(
      input logic       is_instr,
      input mem_size_t  size,
      input logic [1:0] off
   );
      logic bad;
      bad = (off != 2'b00);
      if (!is_instr) begin
         case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = off[0];
            default: bad = (off != 2'b00);
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: big-endian lane steering for stores and
// lane extraction plus sign/zero extension for loads.
module mem_lane
   import core_pkg::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  off,
   input  logic        uns,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // byte 0 is the most significant lane
   always_comb begin
      ld_byte = ld_word[31:24];
      case (off)
         2'd1:    ld_byte = ld_word[23:16];
         2'd2:    ld_byte = ld_word[15:8];
         2'd3:    ld_byte = ld_word[7:0];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = off[1] ? ld_word[15:0] : ld_word[31:16];
   end

   // store strobes/replication and load extension by size
   always_comb begin
      wstrb   = 4'b1111;
      wdata   = st_data;
      ld_data = ld_word;
      case (size)
         MEM_B: begin
            wstrb   = 4'b1000 >> off;
            wdata   = {4{st_data[7:0]}};
            ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
         end
         MEM_H: begin
            wstrb   = 4'b1100 >> off;
            wdata   = {2{st_data[15:0]}};
            ld_data = {{16{~uns & ld_half[15]}}, ld_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one AXI4-Lite master between
// instruction fetch and load/store with round-robin grant.
module mem_port_arbiter
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        done,
   output logic        done_is_instr,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [2:0]  fault_vec,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic        m_is_instr,
   input  logic        m_throw_exception,
   input  logic [2:0]  m_exception_vec
);

   arb_state_t  state, state_nxt;
   mem_txn_t    txn, req_sel;
   logic        prio_data;
   logic        gnt_d, gnt_i, gnt_bad;
   logic        aw_done, w_done;
   logic        aw_hs, w_hs;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic [2:0]  fvec_q;
   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata, lane_ld;

   assign gnt_d = (state == IDLE) && d_req
                  && (!if_req || prio_data);
   assign gnt_i = (state == IDLE) && if_req && !gnt_d;
   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid && m_axi_wready;

   // request selected by the grant, ready to latch
   always_comb begin
      req_sel.is_instr = gnt_i;
      req_sel.size     = gnt_i ? MEM_W : mem_size_t'(d_size);
      req_sel.uns      = !gnt_i && d_unsigned;
      req_sel.addr     = gnt_i ? if_addr : d_addr;
      req_sel.wdata    = d_wdata;
   end

   assign gnt_bad = misaligned(req_sel.is_instr,
                               req_sel.size,
                               req_sel.addr[1:0]);

   mem_lane u_lane (
      .size    (txn.size),
      .off     (txn.addr[1:0]),
      .uns     (txn.uns),
      .st_data (txn.wdata),
      .ld_word (m_axi_rdata),
      .wstrb   (lane_wstrb),
      .wdata   (lane_wdata),
      .ld_data (lane_ld)
   );

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state: grant, AXI phase sequencing, done pulse
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (gnt_d || gnt_i) begin
               if (gnt_bad)             state_nxt = DONE;
               else if (gnt_d && d_we)  state_nxt = W;
               else                     state_nxt = AR;
            end
         end
         AR:   if (m_axi_arready) state_nxt = R;
         R:    if (m_axi_rvalid)  state_nxt = DONE;
         W: begin
            if ((aw_done || aw_hs) && (w_done || w_hs))
               state_nxt = B;
         end
         B:    if (m_axi_bvalid)  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state and latched transaction
   always_comb begin
      m_axi_arvalid = (state == AR);
      m_axi_araddr  = (state == AR)
                      ? {txn.addr[31:2], 2'b00} : '0;
      m_axi_rready  = (state == R);
      m_axi_awvalid = (state == W) && !aw_done;
      m_axi_awaddr  = (state == W)
                      ? {txn.addr[31:2], 2'b00} : '0;
      m_axi_wvalid  = (state == W) && !w_done;
      m_axi_wdata   = (state == W) ? lane_wdata : '0;
      m_axi_wstrb   = (state == W) ? lane_wstrb : '0;
      m_axi_bready  = (state == B);
      done          = (state == DONE);
      done_is_instr = (state == DONE) && txn.is_instr;
      rdata         = (state == DONE) ? rdata_q : '0;
      fault         = (state == DONE) && fault_q;
      fault_vec     = (state == DONE) ? fvec_q : '0;
      m_is_instr    = (state != IDLE) && txn.is_instr;
   end

   // grant bookkeeping: latch request, ack pulse, rotate priority
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         txn       <= '0;
         prio_data <= 1'b1;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
      end else begin
         if_ack <= gnt_i;
         d_ack  <= gnt_d;
         if (gnt_i || gnt_d) begin
            txn       <= req_sel;
            prio_data <= gnt_i;
         end
      end
   end

   // remember which write channels already handshook
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state != W) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

   // completion result capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= '0;
         fault_q <= 1'b0;
         fvec_q  <= '0;
      end else if ((gnt_i || gnt_d) && gnt_bad) begin
         rdata_q <= '0;
         fault_q <= 1'b1;
         fvec_q  <= MISALIGN_VEC;
      end else if (state == R && m_axi_rvalid) begin
         fault_q <= m_throw_exception;
         fvec_q  <= m_throw_exception ? m_exception_vec : '0;
         rdata_q <= m_throw_exception ? '0 : lane_ld;
      end else if (state == B && m_axi_bvalid) begin
         fault_q <= m_throw_exception;
         fvec_q  <= m_throw_exception ? m_exception_vec : '0;
         rdata_q <= '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared
// memory port, one task per scenario.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic        done;
   logic        done_is_instr;
   logic [31:0] rdata;
   logic        fault;
   logic [2:0]  fault_vec;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic        m_is_instr;
   logic        m_throw_exception;
   logic [2:0]  m_exception_vec;

   typedef struct packed {
      logic        is_instr;
      logic [31:0] rdata;
      logic        fault;
      logic [2:0]  vec;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_exp;
   exp_t mon_got;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk               (clk),
      .rstn              (rstn),
      .if_req            (if_req),
      .if_addr           (if_addr),
      .if_ack            (if_ack),
      .d_req             (d_req),
      .d_we              (d_we),
      .d_size            (d_size),
      .d_unsigned        (d_unsigned),
      .d_addr            (d_addr),
      .d_wdata           (d_wdata),
      .d_ack             (d_ack),
      .done              (done),
      .done_is_instr     (done_is_instr),
      .rdata             (rdata),
      .fault             (fault),
      .fault_vec         (fault_vec),
      .m_axi_arvalid     (m_axi_arvalid),
      .m_axi_arready     (m_axi_arready),
      .m_axi_araddr      (m_axi_araddr),
      .m_axi_rvalid      (m_axi_rvalid),
      .m_axi_rready      (m_axi_rready),
      .m_axi_rdata       (m_axi_rdata),
      .m_axi_awvalid     (m_axi_awvalid),
      .m_axi_awready     (m_axi_awready),
      .m_axi_awaddr      (m_axi_awaddr),
      .m_axi_wvalid      (m_axi_wvalid),
      .m_axi_wready      (m_axi_wready),
      .m_axi_wdata       (m_axi_wdata),
      .m_axi_wstrb       (m_axi_wstrb),
      .m_axi_bvalid      (m_axi_bvalid),
      .m_axi_bready      (m_axi_bready),
      .m_is_instr        (m_is_instr),
      .m_throw_exception (m_throw_exception),
      .m_exception_vec   (m_exception_vec)
   );

   // scoreboard: every completion pops one expected result
   always @(negedge clk) begin
      if (rstn && done) begin
         mon_got = {done_is_instr, rdata, fault, fault_vec};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got=%h", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL done_result instr=%0b rdata=%h fault=%0b vec=%0d want instr=%0b rdata=%h fault=%0b vec=%0d",
                        mon_got.is_instr, mon_got.rdata, mon_got.fault, mon_got.vec,
                        mon_exp.is_instr, mon_exp.rdata, mon_exp.fault, mon_exp.vec);
            end
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      if_req = 0; if_addr = 0;
      d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0;
      d_addr = 0; d_wdata = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_throw_exception = 0; m_exception_vec = 0;
      #1;
      checks++;
      if ({if_ack, d_ack, done, done_is_instr, fault, m_axi_arvalid,
           m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_is_instr} !== 11'b0 || rdata !== 0 || fault_vec !== 0
          || m_axi_araddr !== 0 || m_axi_awaddr !== 0
          || m_axi_wdata !== 0 || m_axi_wstrb !== 0) begin
         errors++;
         $display("FAIL reset_outputs ctl=%b rdata=%h strb=%b want all zero",
                  {if_ack, d_ack, done, m_axi_arvalid, m_axi_rready,
                   m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_is_instr},
                  rdata, m_axi_wstrb);
      end
      repeat (3) cyc();
      rstn = 1'b1;
      cyc();
      checks++;
      if ({done, m_axi_arvalid, m_axi_awvalid, m_axi_wstrb} !== 7'b0) begin
         errors++;
         $display("FAIL idle_outputs got=%b want 0",
                  {done, m_axi_arvalid, m_axi_awvalid, m_axi_wstrb});
      end
   endtask

   task automatic run_read(
      input string       name,
      input logic        instr,
      input logic [31:0] addr,
      input logic [1:0]  size,
      input logic        uns,
      input int          ar_wait,
      input int          r_wait,
      input logic [31:0] word,
      input logic        exc,
      input logic [2:0]  vec,
      input logic [31:0] exp_rd
   );
      exp_t e;
      e = {instr, exc ? 32'h0 : exp_rd, exc, exc ? vec : 3'd0};
      exp_q.push_back(e);
      if (instr) begin
         if_req = 1; if_addr = addr;
      end else begin
         d_req = 1; d_we = 0; d_size = size;
         d_unsigned = uns; d_addr = addr;
      end
      cyc();
      if_req = 0; d_req = 0;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== {addr[31:2], 2'b00}) begin
         errors++;
         $display("FAIL %s_ar valid=%0b addr=%h want 1 %h", name,
                  m_axi_arvalid, m_axi_araddr, {addr[31:2], 2'b00});
      end
      checks++;
      if ((instr ? if_ack : d_ack) !== 1'b1 || m_is_instr !== instr) begin
         errors++;
         $display("FAIL %s_ack ack=%0b/%0b is_instr=%0b want instr=%0b",
                  name, if_ack, d_ack, m_is_instr, instr);
      end
      for (int k = 0; k < ar_wait; k++) begin
         cyc();
         checks++;
         if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_ar_hold valid=%0b addr=%h", name,
                     m_axi_arvalid, m_axi_araddr);
         end
      end
      m_axi_arready = 1;
      cyc();
      m_axi_arready = 0;
      checks++;
      if (m_axi_rready !== 1'b1 || m_axi_arvalid !== 1'b0
          || m_is_instr !== instr) begin
         errors++;
         $display("FAIL %s_r rready=%0b arvalid=%0b is_instr=%0b want 1 0 %0b",
                  name, m_axi_rready, m_axi_arvalid, m_is_instr, instr);
      end
      repeat (r_wait) cyc();
      m_axi_rvalid = 1; m_axi_rdata = word;
      m_throw_exception = exc; m_exception_vec = vec;
      cyc();
      m_axi_rvalid = 0; m_axi_rdata = 0;
      m_throw_exception = 0; m_exception_vec = 0;
      checks++;
      if (done !== 1'b1 || m_is_instr !== instr) begin
         errors++;
         $display("FAIL %s_done_latency done=%0b is_instr=%0b want 1 %0b",
                  name, done, m_is_instr, instr);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || m_is_instr !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_width done=%0b is_instr=%0b want 0 0",
                  name, done, m_is_instr);
      end
   endtask

   task automatic run_write(
      input string       name,
      input logic [31:0] addr,
      input logic [1:0]  size,
      input logic [31:0] wd,
      input int          aw_wait,
      input int          w_wait,
      input int          b_wait,
      input logic        exc,
      input logic [2:0]  vec,
      input logic [3:0]  exp_strb,
      input logic [31:0] exp_wdata
   );
      exp_t e;
      int   nmax;
      e = {1'b0, 32'h0, exc, exc ? vec : 3'd0};
      exp_q.push_back(e);
      nmax = (aw_wait > w_wait) ? aw_wait : w_wait;
      d_req = 1; d_we = 1; d_size = size; d_unsigned = 0;
      d_addr = addr; d_wdata = wd;
      cyc();
      d_req = 0; d_we = 0;
      checks++;
      if (m_axi_wstrb !== exp_strb || m_axi_wdata !== exp_wdata
          || m_axi_awaddr !== {addr[31:2], 2'b00} || d_ack !== 1'b1) begin
         errors++;
         $display("FAIL %s_lanes strb=%b wdata=%h awaddr=%h ack=%0b want %b %h %h 1",
                  name, m_axi_wstrb, m_axi_wdata, m_axi_awaddr, d_ack,
                  exp_strb, exp_wdata, {addr[31:2], 2'b00});
      end
      for (int k = 0; k <= nmax; k++) begin
         checks++;
         if (m_axi_awvalid !== (k <= aw_wait)
             || m_axi_wvalid !== (k <= w_wait)) begin
            errors++;
            $display("FAIL %s_valids k=%0d aw=%0b w=%0b want %0b %0b",
                     name, k, m_axi_awvalid, m_axi_wvalid,
                     (k <= aw_wait), (k <= w_wait));
         end
         m_axi_awready = (k == aw_wait);
         m_axi_wready  = (k == w_wait);
         cyc();
      end
      m_axi_awready = 0; m_axi_wready = 0;
      checks++;
      if (m_axi_bready !== 1'b1 || m_axi_awvalid !== 1'b0
          || m_axi_wvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_b bready=%0b aw=%0b w=%0b want 1 0 0",
                  name, m_axi_bready, m_axi_awvalid, m_axi_wvalid);
      end
      repeat (b_wait) cyc();
      m_axi_bvalid = 1; m_throw_exception = exc; m_exception_vec = vec;
      cyc();
      m_axi_bvalid = 0; m_throw_exception = 0; m_exception_vec = 0;
      checks++;
      if (done !== 1'b1 || m_axi_bready !== 1'b0) begin
         errors++;
         $display("FAIL %s_done done=%0b bready=%0b want 1 0",
                  name, done, m_axi_bready);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || m_axi_bready !== 1'b0) begin
         errors++;
         $display("FAIL %s_after done=%0b bready=%0b want 0 0",
                  name, done, m_axi_bready);
      end
   endtask

   task automatic run_misaligned(
      input string       name,
      input logic        instr,
      input logic        we,
      input logic [31:0] addr,
      input logic [1:0]  size
   );
      exp_t e;
      e = {instr, 32'h0, 1'b1, 3'd0};
      exp_q.push_back(e);
      if (instr) begin
         if_req = 1; if_addr = addr;
      end else begin
         d_req = 1; d_we = we; d_size = size;
         d_unsigned = 0; d_addr = addr; d_wdata = 32'hFFFF_FFFF;
      end
      cyc();
      if_req = 0; d_req = 0; d_we = 0;
      checks++;
      if (done !== 1'b1 || m_axi_arvalid !== 1'b0
          || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_fast done=%0b ar=%0b aw=%0b w=%0b want 1 0 0 0",
                  name, done, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || m_axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_after done=%0b ar=%0b want 0 0",
                  name, done, m_axi_arvalid);
      end
   endtask

   task automatic test_arbitration();
      exp_t        e;
      logic [31:0] a;
      int          n;
      logic        want_i;
      for (int t = 0; t < 4; t++) begin
         e = {t[0], t[0] ? 32'hA000_0600 : 32'hA000_0500, 1'b0, 3'd0};
         exp_q.push_back(e);
      end
      if_req = 1; if_addr = 32'h600;
      d_req = 1; d_we = 0; d_size = 2'd2; d_unsigned = 0;
      d_addr = 32'h500;
      for (int t = 0; t < 4; t++) begin
         want_i = t[0];
         n = 0;
         while (m_axi_arvalid !== 1'b1 && n < 10) begin
            cyc();
            n++;
         end
         checks++;
         if (m_axi_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL arb_timeout grant=%0d arvalid=%0b want 1",
                     t, m_axi_arvalid);
         end else if (if_ack !== want_i || d_ack !== !want_i
                      || m_is_instr !== want_i) begin
            errors++;
            $display("FAIL arb_order grant=%0d if_ack=%0b d_ack=%0b want fetch=%0b",
                     t, if_ack, d_ack, want_i);
         end
         a = m_axi_araddr;
         m_axi_arready = 1;
         cyc();
         m_axi_arready = 0;
         m_axi_rvalid = 1; m_axi_rdata = 32'hA000_0000 | a;
         cyc();
         m_axi_rvalid = 0; m_axi_rdata = 0;
         if (t == 3) begin
            if_req = 0; d_req = 0;
         end
         checks++;
         if (done !== 1'b1 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL arb_done grant=%0d done=%0b acks=%0b%0b want 1 00",
                     t, done, if_ack, d_ack);
         end
      end
      cyc();
      cyc();
      checks++;
      if (m_axi_arvalid !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
         errors++;
         $display("FAIL arb_quiet ar=%0b acks=%0b%0b want 0 00",
                  m_axi_arvalid, if_ack, d_ack);
      end
   endtask

   task automatic test_fetch();
      run_read("fetch", 1, 32'h100, 2'd2, 0, 0, 0,
               32'hDEAD_BEEF, 0, 3'd0, 32'hDEAD_BEEF);
   endtask

   task automatic test_loads();
      run_read("lb",  0, 32'h203, 2'd0, 0, 0, 0,
               32'h1122_33F0, 0, 3'd0, 32'hFFFF_FFF0);
      run_read("lbu", 0, 32'h203, 2'd0, 1, 0, 0,
               32'h1122_33F0, 0, 3'd0, 32'h0000_00F0);
      run_read("lb0", 0, 32'h200, 2'd0, 0, 1, 0,
               32'h7F80_0000, 0, 3'd0, 32'h0000_007F);
      run_read("lh",  0, 32'h202, 2'd1, 0, 2, 1,
               32'h1122_8001, 0, 3'd0, 32'hFFFF_8001);
      run_read("lhu", 0, 32'h200, 2'd1, 1, 0, 2,
               32'h8001_7FFF, 0, 3'd0, 32'h0000_8001);
      run_read("lw",  0, 32'h404, 2'd2, 0, 0, 0,
               32'hCAFE_F00D, 0, 3'd0, 32'hCAFE_F00D);
   endtask

   task automatic test_stores();
      run_write("sh", 32'h302, 2'd1, 32'h0000_ABCD, 0, 2, 0,
                0, 3'd0, 4'b0011, 32'hABCD_ABCD);
      run_write("sb", 32'h301, 2'd0, 32'h0000_00A5, 0, 0, 0,
                0, 3'd0, 4'b0100, 32'hA5A5_A5A5);
      run_write("sw", 32'h400, 2'd2, 32'h1122_3344, 1, 0, 2,
                0, 3'd0, 4'b1111, 32'h1122_3344);
   endtask

   task automatic test_faults();
      run_misaligned("lw_mis", 0, 0, 32'h401, 2'd2);
      run_misaligned("if_mis", 1, 0, 32'h102, 2'd2);
      run_misaligned("sh_mis", 0, 1, 32'h301, 2'd1);
      run_read("lw_exc", 0, 32'h408, 2'd2, 0, 0, 0,
               32'h5555_AAAA, 1, 3'd5, 32'h0);
      run_write("sw_exc", 32'h40C, 2'd2, 32'h0BAD_0BAD, 0, 0, 1,
                1, 3'd3, 4'b1111, 32'h0BAD_0BAD);
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h700;
      cyc();
      if_req = 0;
      m_axi_arready = 1;
      cyc();
      m_axi_arready = 0;
      checks++;
      if (m_axi_rready !== 1'b1 || m_is_instr !== 1'b1) begin
         errors++;
         $display("FAIL midrst_setup rready=%0b is_instr=%0b want 1 1",
                  m_axi_rready, m_is_instr);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({if_ack, d_ack, done, done_is_instr, fault, m_axi_arvalid,
           m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_is_instr} !== 11'b0 || rdata !== 0 || fault_vec !== 0
          || m_axi_araddr !== 0 || m_axi_awaddr !== 0
          || m_axi_wdata !== 0 || m_axi_wstrb !== 0) begin
         errors++;
         $display("FAIL midrst_outputs rready=%0b is_instr=%0b ctl=%b want all zero",
                  m_axi_rready, m_is_instr,
                  {done, m_axi_arvalid, m_axi_awvalid, m_axi_bready});
      end
      cyc();
      cyc();
      rstn = 1'b1;
      cyc();
      run_read("post_rst", 0, 32'h704, 2'd2, 0, 0, 0,
               32'h1234_5678, 0, 3'd0, 32'h1234_5678);
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_fetch();
      test_loads();
      test_stores();
      test_faults();
      test_reset_mid();
      repeat (2) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single AXI4-Lite memory master between the instruction-fetch requester and the load/store requester. Sequences each AXI read or write handshake, and performs big-endian byte-lane alignment, sign/zero extension and misalignment checks. Returns a one-cycle completion pulse carrying data and fault status. Sits between the core state machine and the MMU.

## Interface
- No parameters; data and address widths are fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rstn`).
- `clk`  in  1  clock
- `rstn`  in  1  async active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  32  fetch address
- `if_ack`  out  1  fetch request accepted (1-cycle pulse)
- `d_req`  in  1  load/store request
- `d_we`  in  1  1 = store
- `d_size`  in  2  `MEM_B`/`MEM_H`/`MEM_W`
- `d_unsigned`  in  1  zero-extend load
- `d_addr`  in  32  byte address
- `d_wdata`  in  32  store data, right-aligned
- `d_ack`  out  1  data request accepted (1-cycle pulse)
- `done`  out  1  completion pulse for the granted requester
- `done_is_instr`  out  1  1 = completion belongs to fetch
- `rdata`  out  32  fetch word or extended load result
- `fault`  out  1  misaligned or MMU exception
- `fault_vec`  out  3  captured `m_exception_vec`; 0 for misalignment
- `m_axi_ar*`, `m_axi_r*`, `m_axi_aw*`, `m_axi_w*`, `m_axi_b*`  AXI4-Lite master, standard directions/widths
- `m_is_instr`  out  1  current transaction is a fetch
- `m_throw_exception`  in  1  MMU fault
- `m_exception_vec`  in  3  MMU fault cause

## Operation
- States: `IDLE`, `AR`, `R`, `W`, `B`, `DONE`.
- **Grant (IDLE only):**
  - If both requests are high, round-robin applies: the requester not granted last wins. Reset state favours data.
  - The grant asserts `*_ack` and latches address, size, data and kind.
  - The requester may drop `req` after ack. A `req` still high after `done` counts as a new request.
- **Misalignment check at grant:** `MEM_H` with `addr[0]`, `MEM_W` with `addr[1:0]≠0`, or a fetch with `if_addr[1:0]≠0`.
  - Go straight to `DONE` with `fault=1`, `fault_vec=0`, and no bus activity.
- **Read path (fetch or load):**
  - `AR`: `m_axi_arvalid=1`, `araddr={addr[31:2],2'b00}`. Leave on `arready`.
  - `R`: `rready=1`. Leave on `rvalid`, sampling `rdata` and `m_throw_exception`.
- **Write path:**
  - `W`: `awvalid` and `wvalid` both asserted. Each drops independently on its own ready. Leave when both have handshaken (same or different cycles).
  - `B`: `bready=1`. Leave on `bvalid`, sampling the exception.
- **`DONE`:** `done=1` for exactly one cycle, then `IDLE`. No grant is issued in `DONE`.
- **Big-endian lanes**, with `off=addr[1:0]`:
  - Byte `off` occupies `[31-8·off -: 8]`.
  - Store strobes: `wstrb = 4'b1000>>off` (B), `4'b1100>>off` (H), `4'b1111` (W).
  - Store data: `wdata` replicates the byte ×4 or the halfword ×2.
  - Load: extract the selected lane, then sign-extend, or zero-extend when `d_unsigned`. A fetch returns the full word.
- **Faults:** when `fault=1`, `rdata=0`.
- **`m_is_instr`:** stable from `AR` entry through `DONE` for fetch. 0 for data transactions.
- **Reset mid-operation:** all outputs clear immediately and the state returns to `IDLE`. The outstanding AXI transaction is abandoned; the MMU is reset together with the arbiter.

## Timing
- Reset values: all outputs 0, including every valid, ready, strobe, address and data output. Round-robin pointer = data.
- Read: request in cycle 0 (IDLE) → `arvalid` in cycle 1.
  - With `arready` in cycle 1, `rready` is high in cycle 2.
  - With `rvalid` in cycle 2, `done` is high in cycle 3. Minimum latency is 3 cycles.
  - Each wait cycle on ready/valid adds exactly 1 cycle.
- Write: minimum latency is also 3 cycles (cycle 1 aw/w, cycle 2 b, cycle 3 done).
- Misaligned access: `done` in cycle 1.
- Valids are never withdrawn before their handshake. `araddr`, `awaddr`, `wdata` and `wstrb` stay stable while their valid is high.
- Back-to-back requests: the earliest next grant is the cycle after `DONE`.

## Structure
- Shared package `core_pkg`:
  - `mem_size_t` enum (`MEM_B=0`, `MEM_H=1`, `MEM_W=2`).
  - `arb_state_t` enum.
  - `MISALIGN_VEC=3'd0`.
- Sub-module `mem_lane`: purely combinational. Computes store `wstrb`/`wdata` replication and load extraction/extension from size, offset and unsigned flag.

## Test plan
- Fetch at `0x100`, `arready`/`rvalid` immediate, `rdata=0xDEADBEEF` → `done` at cycle 3, `rdata=0xDEADBEEF`, `done_is_instr=1`, `m_is_instr=1` throughout.
- `lb` at `0x203`, `rdata=0x112233F0` → `rdata=0xFFFFFFF0`. Same access as `lbu` → `0x000000F0`.
- `sh` at `0x302`, `d_wdata=0x0000ABCD` → `wstrb=4'b0011`, `wdata=0xABCDABCD`. `awready` 2 cycles before `wready` → single `bready` phase, `done` once.
- `if_req` and `d_req` asserted together twice in a row → grants alternate: data, fetch, data, fetch.
- `lw` at `0x401` → `done` at cycle 1, `fault=1`, `fault_vec=0`, no `arvalid`. Then a read with `m_throw_exception=1`, `vec=3'd5` at `rvalid` → `fault=1`, `fault_vec=5`, `rdata=0`.
- `rstn` pulled low while in `R` → all outputs 0 asynchronously. After release, the next request is granted from `IDLE` normally.
